// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sequencer states, parity encodings and parity helpers.
// Used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Encoding 2'b11 is treated like PAR_NONE.
  function automatic logic parity_enabled(input logic [1:0] sel);
    return (sel == PAR_EVEN) || (sel == PAR_ODD);
  endfunction

  // The payload is zero-extended to 8 bits; the padding does not change the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] sel);
    return (^data) ^ (sel == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Producer-side interface of the UART transmitter.
// Carries the payload handshake, the frame format selects and the serial/status outputs.
interface uart_tx_if #(
  parameter int DATA_BITS = 8
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [1:0]           parity_sel;
  logic                 stop_sel;
  logic                 tx;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_valid, parity_sel, stop_sel,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid, parity_sel, stop_sel,
    output tx_ready, tx, tx_busy, tx_done
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: serialises one latched payload per handshake as start, data (LSB first),
// optional parity and one or two stop bits, paced by an external bit-period tick.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     tick,
  uart_tx_if.slave bus
);

  localparam int               CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  uart_state_e          state_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic                 stop_cnt_r;
  logic                 par_en_r;
  logic                 par_bit_r;
  logic                 stop2_r;
  logic                 tx_r;
  logic                 tx_ready_r;
  logic                 tx_busy_r;
  logic                 tx_done_r;
  logic [7:0]           data_ext_s;

  // Widen the payload to the fixed width the shared parity helper expects.
  always_comb begin
    data_ext_s                  = 8'h00;
    data_ext_s[DATA_BITS-1:0]   = bus.tx_data;
  end

  // Frame sequencer: state, frame registers and every output are updated together here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      shift_r    <= '0;
      bit_cnt_r  <= '0;
      stop_cnt_r <= 1'b0;
      par_en_r   <= 1'b0;
      par_bit_r  <= 1'b0;
      stop2_r    <= 1'b0;
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.tx_valid && tx_ready_r) begin
            shift_r    <= bus.tx_data;
            par_en_r   <= parity_enabled(bus.parity_sel);
            par_bit_r  <= parity_bit(data_ext_s, bus.parity_sel);
            stop2_r    <= bus.stop_sel;
            tx_ready_r <= 1'b0;
            tx_busy_r  <= 1'b1;
            state_r    <= SYNC;
          end
        end
        // SYNC waits for a tick so the start bit always spans a whole interval.
        SYNC: begin
          if (tick) begin
            state_r <= START;
            tx_r    <= 1'b0;
          end
        end
        START: begin
          if (tick) begin
            state_r   <= DATA;
            tx_r      <= shift_r[0];
            bit_cnt_r <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt_r == LAST_BIT) begin
              bit_cnt_r <= '0;
              if (par_en_r) begin
                state_r <= PARITY;
                tx_r    <= par_bit_r;
              end else begin
                state_r    <= STOP;
                tx_r       <= 1'b1;
                stop_cnt_r <= 1'b0;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + CNT_W'(1);
              shift_r   <= shift_r >> 1;
              tx_r      <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_r    <= STOP;
            tx_r       <= 1'b1;
            stop_cnt_r <= 1'b0;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop2_r && !stop_cnt_r) begin
              stop_cnt_r <= 1'b1;
            end else begin
              state_r    <= IDLE;
              stop_cnt_r <= 1'b0;
              tx_done_r  <= 1'b1;
              tx_ready_r <= 1'b1;
              tx_busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          tx_r       <= 1'b1;
          tx_ready_r <= 1'b1;
          tx_busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx       = tx_r;
  assign bus.tx_ready = tx_ready_r;
  assign bus.tx_busy  = tx_busy_r;
  assign bus.tx_done  = tx_done_r;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning payload width per frame, legal 5..8.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port tick  input  1  one-cycle bit-period strobe from baud_rate_generator; one tick per bit interval.
REQ-005 SHALL have port tx_data  input  DATA_BITS  payload, LSB transmitted first.
REQ-006 SHALL have port tx_valid  input  1  producer holds payload valid.
REQ-007 SHALL have port tx_ready  output  1  high when a new payload can be accepted.
REQ-008 SHALL have port parity_sel  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-009 SHALL have port stop_sel  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port tx  output  1  serial line, idle high.
REQ-011 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse when a frame completes.

Function
REQ-013 SHALL implement states IDLE, SYNC, START, DATA, PARITY, STOP.
REQ-014 SHALL drive tx_ready=1 only in IDLE; handshake completes on any cycle with tx_valid && tx_ready.
REQ-015 SHALL on handshake latch tx_data, parity_sel and stop_sel into internal registers and enter SYNC; later changes to those inputs SHALL NOT affect the frame.
REQ-016 SHALL in SYNC hold tx=1 and move to START on the next tick, so the start bit is a full bit interval.
REQ-017 SHALL advance START->DATA, DATA bit-to-bit, DATA->PARITY or STOP, PARITY->STOP, and STOP->IDLE only on cycles where tick=1.
REQ-018 SHALL drive tx=0 in START, tx=shift register bit 0 in DATA, tx=parity bit in PARITY, tx=1 in STOP, SYNC and IDLE.
REQ-019 SHALL count data bits with a counter of width clog2(DATA_BITS); leave DATA after DATA_BITS ticks.
REQ-020 SHALL skip PARITY when latched parity_sel is 00 or 11.
REQ-021 SHALL compute parity as XOR of latched data for even, its inverse for odd.
REQ-022 SHALL hold STOP for one tick interval when stop_sel=0, two when stop_sel=1.
REQ-023 SHALL assert tx_done for exactly one cycle, in the cycle after the tick ending the last stop bit; tx_ready SHALL rise in the same cycle.
REQ-024 SHALL allow back-to-back frames: a handshake in the first IDLE cycle SHALL start the next frame with no extra idle bit beyond SYNC.
REQ-025 SHALL drive tx_busy = (state != IDLE).
REQ-026 SHALL register tx, tx_ready, tx_busy and tx_done; no combinational path from inputs to outputs.
REQ-027 SHALL ignore tick while in IDLE.
REQ-028 SHALL ignore tx_valid outside IDLE; a producer holding tx_valid SHALL be accepted once tx_ready rises.

Reset
REQ-029 SHALL, with rst=1 at a clock edge, set state=IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, and clear counters and the shift register.
REQ-030 SHALL on reset mid-frame abort immediately, returning tx to 1 on the next edge with no tx_done pulse.
REQ-031 SHALL give rst priority over tick and handshake in the same cycle.

Structure
REQ-032 SHALL take the state enum and parity encoding constants (PAR_NONE, PAR_EVEN, PAR_ODD) from shared package uart_pkg, which the receiver also uses.
REQ-033 SHALL contain no sub-module; baud_rate_generator is instantiated beside uart_tx at top level and tick is wired in.

Verification
REQ-034 SHALL cover tick every 16 cycles, parity none, 1 stop, tx_data=0x55 -> tx sequence 0,1,0,1,0,1,0,1,0,1 at 16 cycles per bit, then tx_done pulse once.
REQ-035 SHALL cover parity even with 0x07 -> parity bit 1; parity odd with 0x07 -> parity bit 0; frame length 11 bit intervals.
REQ-036 SHALL cover stop_sel=1 with 0xA3 -> stop high for 2 intervals; tx_done 1 cycle after the 2nd stop tick.
REQ-037 SHALL cover tx_valid held high with 0x11 then 0x22 -> second frame's SYNC starts the cycle tx_ready rises; exactly two tx_done pulses.
REQ-038 SHALL cover rst=1 during DATA bit 3 -> tx=1, tx_ready=1 next cycle, no tx_done, next frame 0xFF correct.
REQ-039 SHALL cover parity_sel changed mid-frame from 00 to 01 -> current frame has no parity bit.
